// File: rtl/dac_axi_pkg.sv
// dac_axi_pkg: shared AXI response codes, slave FSM states and default waveform RAM depth
package dac_axi_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int DEF_MEM_DEPTH = 1024;
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
endpackage

// File: rtl/dac_wave_axi_slave_if.sv
// dac_wave_axi_slave_if: AXI4 write channels (AW, W, B) between the CCU master and the DAC slave
interface dac_wave_axi_slave_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] awaddr;
  logic awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic wvalid, wready, wlast;
  logic [1:0] bresp;
  logic bvalid, bready;
  modport master (
    output awaddr, awvalid, wdata, wvalid, wlast, bready,
    input awready, wready, bresp, bvalid
  );
  modport slave (
    input awaddr, awvalid, wdata, wvalid, wlast, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/dac_wave_ram.sv
// dac_wave_ram: dual-port sample RAM; clk, rst_n (clears read register only), we/waddr/wdata write port, raddr/rdata registered read port returning old data on collision
module dac_wave_ram #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**MEM_AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/dac_wave_axi_slave.sv
// dac_wave_axi_slave: AXI4 write-only waveform loader; axi_aclk/axi_aresetn, axi (AW/W/B slave channels), rd_addr/rd_data playback port, wave_len/wave_update published after each OKAY burst
module dac_wave_axi_slave
  import dac_axi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MEM_AW = $clog2(MEM_DEPTH)
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  dac_wave_axi_slave_if.slave axi,
  input  logic [MEM_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [MEM_AW:0]   wave_len,
  output logic              wave_update
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  state_t state, state_d;
  logic [ADDR_W:0] ptr, ptr_d;
  logic err, err_d, we, in_range, upd_d;
  logic [1:0] bresp_d;
  logic [MEM_AW:0] len_d;
  logic aw_hs, w_hs, b_hs;
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs = axi.wvalid && axi.wready;
  assign b_hs = axi.bvalid && axi.bready;
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    err_d = err;
    bresp_d = axi.bresp;
    len_d = wave_len;
    upd_d = 1'b0;
    we = 1'b0;
    in_range = ptr < DEPTH && !err;
    case (state)
      IDLE: if (aw_hs) begin
        state_d = DATA;
        ptr_d = {1'b0, axi.awaddr};
        err_d = {1'b0, axi.awaddr} >= DEPTH;
      end
      DATA: if (w_hs) begin
        we = in_range;
        err_d = !in_range;
        ptr_d = ptr + 1'b1;
        if (axi.wlast) begin
          state_d = RESP;
          bresp_d = in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      RESP: if (b_hs) begin
        state_d = IDLE;
        if (axi.bresp == RESP_OKAY) begin
          len_d = ptr[MEM_AW:0];
          upd_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      state <= IDLE;
      ptr <= '0;
      err <= 1'b0;
      axi.awready <= 1'b0;
      axi.wready <= 1'b0;
      axi.bvalid <= 1'b0;
      axi.bresp <= RESP_OKAY;
      wave_len <= '0;
      wave_update <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      err <= err_d;
      axi.awready <= state_d == IDLE;
      axi.wready <= state_d == DATA;
      axi.bvalid <= state_d == RESP;
      axi.bresp <= bresp_d;
      wave_len <= len_d;
      wave_update <= upd_d;
    end
  dac_wave_ram #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_ram (
    .clk(axi_aclk),
    .rst_n(axi_aresetn),
    .we(we),
    .waddr(ptr[MEM_AW-1:0]),
    .wdata(axi.wdata),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_dac_wave_axi_slave.sv
// tb_dac_wave_axi_slave: scoreboard bench for dac_wave_axi_slave with directed and random bursts
module tb_dac_wave_axi_slave;
  typedef struct {logic [1:0] resp; int len;} bexp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic [10:0] wave_len;
  logic wave_update;
  logic rd_chk;
  int vectors = 0, miscompares = 0;
  logic [7:0] mem_m [1024];
  bit known [1024];
  logic [7:0] bd[$];
  bexp_t b_q[$];
  logic [7:0] rd_q[$];
  int model_len = 0;
  bit upd_pend = 0, rd_pend = 0, b_hold = 0;
  logic [1:0] last_bresp = 2'b00;
  bexp_t e;
  dac_wave_axi_slave_if #(.ADDR_W(16), .DATA_W(8)) axi ();
  dac_wave_axi_slave dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .axi(axi.slave),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wave_len(wave_len),
    .wave_update(wave_update)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  function automatic bit rdy(input int ch);
    return ch == 0 ? axi.awready : ch == 1 ? axi.wready : axi.bvalid;
  endfunction
  task automatic wait_hs(input int ch, input string nm);
    int t = 0;
    @(negedge clk);
    while (!rdy(ch) && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!rdy(ch)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: handshake timed out", nm);
    end
  endtask
  // Reference: beats below 1024 land in RAM, anything reaching past 1024 is SLVERR,
  // and an OKAY burst publishes its end address as the new length.
  task automatic model(input int a);
    int n = bd.size();
    bexp_t x;
    for (int i = 0; i < n; i++)
      if (a + i < 1024) begin
        mem_m[a+i] = bd[i];
        known[a+i] = 1;
      end
    x.resp = (a + n > 1024) ? 2'b10 : 2'b00;
    x.len = a + n;
    b_q.push_back(x);
  endtask
  task automatic aw(input int a);
    axi.awaddr = 16'(a);
    axi.awvalid = 1'b1;
    wait_hs(0, "aw_hs");
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
  endtask
  task automatic wphase(input bit gaps);
    for (int i = 0; i < bd.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      axi.wdata = bd[i];
      axi.wlast = (i == bd.size() - 1);
      axi.wvalid = 1'b1;
      wait_hs(1, "w_hs");
      @(posedge clk); #1;
      axi.wvalid = 1'b0;
      axi.wlast = 1'b0;
    end
  endtask
  task automatic bphase(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    axi.bready = 1'b1;
    wait_hs(2, "b_hs");
    @(posedge clk); #1;
    axi.bready = 1'b0;
  endtask
  task automatic burst(input int a, input bit gaps, input int hold);
    model(a);
    aw(a);
    wphase(gaps);
    bphase(hold);
  endtask
  task automatic rd(input int a);
    rd_addr = 10'(a);
    rd_chk = 1'b1;
    rd_q.push_back(mem_m[a]);
    @(posedge clk); #1;
    rd_chk = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      upd_pend = 0;
      rd_pend = 0;
      b_hold = 0;
      model_len = 0;
      rd_q.delete();
    end else begin
      chk("wave_update", wave_update, upd_pend);
      chk("wave_len", wave_len, model_len);
      upd_pend = 0;
      if (rd_pend) chk("rd_data", rd_data, rd_q.pop_front());
      rd_pend = rd_chk;
      if (b_hold) begin
        chk("bvalid_hold", axi.bvalid, 1);
        chk("bresp_hold", axi.bresp, last_bresp);
      end
      if (axi.bvalid) chk("awready_in_resp", axi.awready, 0);
      if (axi.bvalid && axi.bready) begin
        if (b_q.size() == 0) chk("unexpected_b", 1, 0);
        else begin
          e = b_q.pop_front();
          chk("bresp", axi.bresp, e.resp);
          if (e.resp == 2'b00) begin
            model_len = e.len;
            upd_pend = 1;
          end
        end
      end
      b_hold = axi.bvalid && !axi.bready;
      last_bresp = axi.bresp;
    end
  end
  initial begin
    rst_n = 1'b0;
    axi.awaddr = '0;
    axi.awvalid = 1'b0;
    axi.wdata = '0;
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
    axi.bready = 1'b0;
    rd_addr = '0;
    rd_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_bresp", axi.bresp, 0);
    chk("rst_wave_len", wave_len, 0);
    chk("rst_wave_update", wave_update, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_rst", axi.awready, 1);
    chk("wready_after_rst", axi.wready, 0);
    chk("bvalid_after_rst", axi.bvalid, 0);
    bd = '{8'h11, 8'h22, 8'h33, 8'h44};
    burst(16'h0010, 0, 0);
    for (int i = 16; i < 20; i++) rd(i);
    bd = '{8'h5A};
    burst(16'h0000, 0, 0);
    bd = '{8'hE1, 8'hE2};
    burst(16'h0400, 0, 0);
    for (int i = 16; i < 20; i++) rd(i);
    bd = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    burst(16'h03FE, 0, 0);
    rd(10'h3FE);
    rd(10'h3FF);
    rd(0);
    bd = '{8'h61, 8'h62, 8'h63};
    model(16'h0100);
    aw(16'h0100);
    wphase(1);
    axi.awaddr = 16'h0200;
    axi.awvalid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    axi.bready = 1'b1;
    wait_hs(2, "b_hs_held");
    @(posedge clk); #1;
    axi.bready = 1'b0;
    @(negedge clk);
    chk("aw_after_b", axi.awready, 1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    bd = '{8'h71, 8'h72};
    model(16'h0200);
    wphase(0);
    bphase(0);
    for (int i = 256; i < 259; i++) rd(i);
    rd(512);
    rd(513);
    bd = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    aw(16'h0020);
    for (int i = 0; i < 2; i++) begin
      axi.wdata = bd[i];
      axi.wvalid = 1'b1;
      wait_hs(1, "w_hs_abort");
      @(posedge clk); #1;
      axi.wvalid = 1'b0;
      mem_m[32+i] = bd[i];
      known[32+i] = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_awready", axi.awready, 0);
    chk("abort_wready", axi.wready, 0);
    chk("abort_bvalid", axi.bvalid, 0);
    chk("abort_wave_len", wave_len, 0);
    chk("abort_wave_update", wave_update, 0);
    chk("abort_rd_data", rd_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_awready_after", axi.awready, 1);
    chk("abort_bvalid_after", axi.bvalid, 0);
    rd(32);
    rd(33);
    bd = '{8'h5A};
    burst(16'h0000, 0, 0);
    rd(0);
    for (int k = 0; k < 25; k++) begin
      int a, n, sel, r;
      sel = $urandom_range(0, 9);
      n = $urandom_range(1, 8);
      a = sel < 6 ? $urandom_range(0, 1023) : sel < 8 ? $urandom_range(1016, 1023) : $urandom_range(1024, 65535);
      bd.delete();
      for (int i = 0; i < n; i++) bd.push_back(8'($urandom));
      burst(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      for (int i = a; i < a + n && i < 1024; i++) rd(i);
      r = $urandom_range(0, 1023);
      if (known[r]) rd(r);
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("b_queue_drained", b_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
